imem_loader: RTL and testbench

Byte-serial writer for the sequential Y86-64 core's instruction memory. A host streams program bytes into a byte-addressed memory through a valid/ready handshake. The block also drives the fetch stage's 10-byte combinational read port (`instr`, `imem_error`). While a load is in progress it asserts `cpu_hold` so the PC register does not advance.

---
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-serial host writer for the Y86-64 instruction memory.
// A host session streams bytes into consecutive addresses starting at a
// latched base; the fetch stage reads 10 bytes combinationally at PC.
// cpu_hold stays high for the whole session so the core does not fetch
// from a half-written image.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 20480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [63:0] load_base,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done,
  output logic        load_error,
  output logic [63:0] load_count,
  input  logic [63:0] PC,
  output logic [0:79] instr,
  output logic        imem_error,
  output logic        cpu_hold
);

  localparam int unsigned AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] count_q, count_d;
  logic        error_q, error_d;
  logic        mem_we;

  // Byte storage; deliberately not reset so a loaded image survives reset.
  logic [7:0] mem [MEM_BYTES];

  // The write pointer only advances while it is inside the memory, so it can
  // never wrap from the top of the 64-bit space back into valid addresses.
  logic addr_in_range;
  assign addr_in_range = (addr_q < MEM_LIMIT);

  // Session state, write pointer, byte count and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 64'd0;
      count_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Next-state logic: session start in IDLE, beat handling in LOAD, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    error_d = error_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          addr_d  = load_base;
          count_d = 64'd0;
          error_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_valid) begin
          if (addr_in_range) begin
            mem_we  = 1'b1;
            addr_d  = addr_q + 64'd1;
            count_d = count_q + 64'd1;
          end else begin
            error_d = 1'b1;
          end
          if (load_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory write port; only in-range beats reach here.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q[AW-1:0]] <= load_data;
    end
  end

  assign load_ready = (state_q == LOAD);
  assign load_done  = (state_q == DONE);
  assign cpu_hold   = (state_q != IDLE);
  assign load_error = error_q;
  assign load_count = count_q;

  // Fetch read port: each byte lane uses a 65-bit address so PC near 2^64
  // reads as out-of-range zeros instead of wrapping to low memory.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_rd
      logic [64:0] rd_addr;
      assign rd_addr = {1'b0, PC} + 65'(gi);
      assign instr[8*gi +: 8] = (rd_addr < {1'b0, MEM_LIMIT}) ? mem[rd_addr[AW-1:0]] : 8'h00;
    end
  endgenerate

  assign imem_error = (PC >= MEM_LIMIT);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed sessions from the test plan plus random
// sessions, with a per-cycle comparison against a session-level model.
module tb_imem_loader;

  localparam int unsigned MEM = 20480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [63:0] load_base = 64'd0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'd0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic        load_error;
  logic [63:0] load_count;
  logic [63:0] PC = 64'd0;
  logic [0:79] instr;
  logic        imem_error;
  logic        cpu_hold;

  imem_loader #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done), .load_error(load_error),
    .load_count(load_count),
    .PC(PC), .instr(instr), .imem_error(imem_error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A session is "open" from the edge that takes load_start until the edge
  // that takes the last beat; the cycle after that is the done-pulse cycle.
  bit          m_open = 1'b0;
  bit          m_pulse = 1'b0;
  logic [63:0] m_next = 64'd0;
  logic [63:0] m_count = 64'd0;
  bit          m_err = 1'b0;
  logic [7:0]  m_mem [MEM];
  bit          m_known [MEM];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open  <= 1'b0;
      m_pulse <= 1'b0;
      m_next  <= 64'd0;
      m_count <= 64'd0;
      m_err   <= 1'b0;
    end else if (m_pulse) begin
      m_pulse <= 1'b0;
    end else if (!m_open) begin
      if (load_start) begin
        m_open  <= 1'b1;
        m_next  <= load_base;
        m_count <= 64'd0;
        m_err   <= 1'b0;
      end
    end else if (load_valid) begin
      if (m_next < 64'(MEM)) begin
        m_mem[int'(m_next)]   <= load_data;
        m_known[int'(m_next)] <= 1'b1;
        m_next  <= m_next + 64'd1;
        m_count <= m_count + 64'd1;
      end else begin
        m_err <= 1'b1;
      end
      if (load_last) begin
        m_open  <= 1'b0;
        m_pulse <= 1'b1;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [0:79] e_instr;
    logic [0:79] e_mask;
    logic [64:0] a;
    if (chk_en) begin
      chk("load_ready", 80'(load_ready), 80'(m_open));
      chk("load_done",  80'(load_done),  80'(m_pulse));
      chk("cpu_hold",   80'(cpu_hold),   80'(m_open | m_pulse));
      chk("load_error", 80'(load_error), 80'(m_err));
      chk("load_count", 80'(load_count), 80'(m_count));
      chk("imem_error", 80'(imem_error), 80'(PC >= 64'(MEM)));
      e_instr = '0;
      e_mask  = '0;
      for (int k = 0; k < 10; k++) begin
        a = {1'b0, PC} + 65'(k);
        if (a < 65'(MEM)) begin
          if (m_known[int'(a)]) begin
            e_instr[8*k +: 8] = m_mem[int'(a)];
            e_mask[8*k +: 8]  = 8'hFF;
          end
        end else begin
          e_mask[8*k +: 8] = 8'hFF;
        end
      end
      chk("instr", 80'(instr & e_mask), 80'(e_instr));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0]  prog [7] = '{8'h61, 8'h23, 8'h20, 8'h34, 8'h25, 8'h53, 8'h00};
  logic [7:0]  ovf  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [63:0] cur_base = 64'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [63:0] base);
    load_start = 1'b1;
    load_base  = base;
    cur_base   = base;
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rnd_pc();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 5)      PC = cur_base + 64'($urandom_range(0, 12)) - 64'd2;
    else if (r < 8) PC = 64'($urandom_range(0, MEM + 10));
    else            PC = {$urandom, $urandom};
  endtask

  initial begin
    chk_en = 1'b1;
    rst_n  = 1'b0;
    repeat (3) step();
    // Reset state
    chk("rst_ready", 80'(load_ready), 80'd0);
    chk("rst_hold",  80'(cpu_hold),   80'd0);
    chk("rst_count", 80'(load_count), 80'd0);
    chk("rst_err",   80'(load_error), 80'd0);
    rst_n = 1'b1;
    step();

    // Session 1: contiguous 7-byte load at 32
    start_session(64'd32);
    chk("s1_ready_rise", 80'(load_ready), 80'd1);
    for (int i = 0; i < 7; i++) send(prog[i], i == 6);
    chk("s1_done_pulse", 80'(load_done), 80'd1);
    chk("s1_ready_low",  80'(load_ready), 80'd0);
    step();
    chk("s1_done_once", 80'(load_done), 80'd0);
    chk("s1_hold_low",  80'(cpu_hold),  80'd0);
    chk("s1_count",     80'(load_count), 80'd7);
    chk("s1_err",       80'(load_error), 80'd0);
    PC = 64'd32;
    #1;
    chk("s1_instr", 80'(instr[0:55]), 80'h61232034255300);

    // Session 2: same image with a bubble before every beat
    start_session(64'd32);
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b0;
      load_data  = 8'hEE;
      load_last  = 1'b1;
      step();
      send(prog[i], i == 6);
    end
    step();
    chk("s2_count", 80'(load_count), 80'd7);
    chk("s2_instr", 80'(instr[0:55]), 80'h61232034255300);

    // Overflow session at MEM-2
    start_session(64'(MEM - 2));
    for (int i = 0; i < 4; i++) send(ovf[i], i == 3);
    step();
    chk("ovf_count", 80'(load_count), 80'd2);
    chk("ovf_err",   80'(load_error), 80'd1);
    PC = 64'(MEM - 2);
    #1;
    chk("ovf_instr", 80'(instr), {16'hAABB, 64'd0});
    repeat (3) step();
    chk("ovf_err_sticky", 80'(load_error), 80'd1);

    // Read boundaries
    PC = 64'(MEM - 3);
    #1;
    chk("bnd_m3_mem",  80'(instr[8:23]),  80'hAABB);
    chk("bnd_m3_zero", 80'(instr[24:79]), 80'd0);
    chk("bnd_m3_err",  80'(imem_error),   80'd0);
    PC = 64'(MEM);
    #1;
    chk("bnd_m_instr", 80'(instr), 80'd0);
    chk("bnd_m_err",   80'(imem_error), 80'd1);
    PC = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("bnd_top_instr", 80'(instr), 80'd0);
    chk("bnd_top_err",   80'(imem_error), 80'd1);

    // Back-to-back: 1-byte session at 0, then start in the first IDLE cycle
    start_session(64'd0);
    chk("b2b_err_cleared", 80'(load_error), 80'd0);
    send(8'h5A, 1'b1);
    step();
    chk("b2b_idle_ready", 80'(load_ready), 80'd0);
    start_session(64'd100);
    chk("b2b_ready_rise", 80'(load_ready), 80'd1);
    send(8'h11, 1'b0);
    load_start = 1'b1;
    load_base  = 64'd0;
    send(8'h22, 1'b0);
    load_start = 1'b0;
    send(8'h33, 1'b0);
    chk("ign_count", 80'(load_count), 80'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hold",  80'(cpu_hold),   80'd0);
    chk("mid_rst_ready", 80'(load_ready), 80'd0);
    chk("mid_rst_count", 80'(load_count), 80'd0);
    step();
    rst_n = 1'b1;
    PC = 64'd100;
    #1;
    chk("rst_keep_mem", 80'(instr[0:23]), 80'h112233);
    PC = 64'd0;
    #1;
    chk("mem0_untouched", 80'(instr[0:7]), 80'h5A);
    step();

    // Random sessions
    for (int s = 0; s < 40; s++) begin
      int unsigned r;
      int unsigned len;
      logic [63:0] base;
      r = $urandom_range(0, 9);
      if (r < 6)      base = 64'($urandom_range(0, MEM - 12));
      else if (r < 9) base = 64'(MEM - 6 + $urandom_range(0, 8));
      else            base = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      len = $urandom_range(1, 10);
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'($urandom);
        load_data  = 8'($urandom);
        load_last  = 1'($urandom);
        rnd_pc();
        step();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      start_session(base);
      for (int i = 0; i < int'(len); i++) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0;
          load_last  = 1'($urandom);
          load_start = 1'($urandom);
          load_base  = {$urandom, $urandom};
          rnd_pc();
          step();
        end
        load_start = (i < int'(len) - 1) ? 1'($urandom) : 1'b0;
        rnd_pc();
        send(8'($urandom), i == int'(len) - 1);
        load_start = 1'b0;
      end
      rnd_pc();
      step();
    end

    repeat (2) step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
